// File: rtl/ysyx_23060061_bus_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM states, master IDs
// and the default bus widths.
package ysyx_23060061_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        M_IFU = 1'b0,
        M_LSU = 1'b1
    } master_id_e;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_MASK_W = BUS_DATA_W / 8;

endpackage

// File: rtl/ysyx_23060061_rr_pick.sv
// Two-input round-robin picker: on a tie the master not granted last wins.
// Purely combinational; the caller owns the last-grant register.
module ysyx_23060061_rr_pick
    import ysyx_23060061_bus_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_e last,
    output master_id_e grant,
    output logic       any
);

    // NOTE: every output gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        any   = |req;
        grant = M_IFU;
        if (req == 2'b11) begin
            grant = (last == M_IFU) ? M_LSU : M_IFU;
        end else if (req[1]) begin
            grant = M_LSU;
        end
    end

endmodule

// File: rtl/ysyx_23060061_mem_arbiter.sv
// Shares one memory slave port between the IFU (m0) and LSU (m1). One transaction
// at a time, round-robin between masters, response routed back to the owner.
module ysyx_23060061_mem_arbiter
    import ysyx_23060061_bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic                  m0_req_we,
    input  logic [ADDR_W-1:0]     m0_req_addr,
    input  logic [DATA_W-1:0]     m0_req_wdata,
    input  logic [DATA_W/8-1:0]   m0_req_wmask,
    output logic                  m0_rsp_valid,
    input  logic                  m0_rsp_ready,
    output logic [DATA_W-1:0]     m0_rsp_rdata,

    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic                  m1_req_we,
    input  logic [ADDR_W-1:0]     m1_req_addr,
    input  logic [DATA_W-1:0]     m1_req_wdata,
    input  logic [DATA_W/8-1:0]   m1_req_wmask,
    output logic                  m1_rsp_valid,
    input  logic                  m1_rsp_ready,
    output logic [DATA_W-1:0]     m1_rsp_rdata,

    output logic                  s_req_valid,
    input  logic                  s_req_ready,
    output logic                  s_req_we,
    output logic [ADDR_W-1:0]     s_req_addr,
    output logic [DATA_W-1:0]     s_req_wdata,
    output logic [DATA_W/8-1:0]   s_req_wmask,
    input  logic                  s_rsp_valid,
    output logic                  s_rsp_ready,
    input  logic [DATA_W-1:0]     s_rsp_rdata,

    output logic                  busy
);

    arb_state_e state;
    master_id_e owner;
    master_id_e last_grant;
    master_id_e pick_grant;
    logic       pick_any;

    ysyx_23060061_rr_pick u_pick (
        .req   ({m1_req_valid, m0_req_valid}),
        .last  (last_grant),
        .grant (pick_grant),
        .any   (pick_any)
    );

    // Reset leaves last_grant at the LSU so the first tie goes to the IFU.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= M_IFU;
            last_grant <= M_LSU;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner <= pick_grant;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (s_req_ready) begin
                        state <= RSP;
                    end
                end
                RSP: begin
                    if (s_rsp_valid && s_rsp_ready) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic in_req;
    logic in_rsp;
    logic own_m0;

    assign in_req = (state == REQ);
    assign in_rsp = (state == RSP);
    assign own_m0 = (owner == M_IFU);
    assign busy   = (state != IDLE);

    // Slave-side request driven only from the registered owner, never from req_valid.
    always_comb begin
        s_req_valid = in_req;
        s_req_we    = 1'b0;
        s_req_addr  = '0;
        s_req_wdata = '0;
        s_req_wmask = '0;
        if (in_req) begin
            if (own_m0) begin
                s_req_we    = m0_req_we;
                s_req_addr  = m0_req_addr;
                s_req_wdata = m0_req_wdata;
                s_req_wmask = m0_req_wmask;
            end else begin
                s_req_we    = m1_req_we;
                s_req_addr  = m1_req_addr;
                s_req_wdata = m1_req_wdata;
                s_req_wmask = m1_req_wmask;
            end
        end
    end

    always_comb begin
        m0_req_ready = in_req &&  own_m0 && s_req_ready;
        m1_req_ready = in_req && !own_m0 && s_req_ready;

        m0_rsp_valid = in_rsp &&  own_m0 && s_rsp_valid;
        m1_rsp_valid = in_rsp && !own_m0 && s_rsp_valid;
        m0_rsp_rdata = (in_rsp &&  own_m0) ? s_rsp_rdata : '0;
        m1_rsp_rdata = (in_rsp && !own_m0) ? s_rsp_rdata : '0;

        s_rsp_ready  = in_rsp && (own_m0 ? m0_rsp_ready : m1_rsp_ready);
    end

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Scoreboard bench for the two-master memory arbiter: bench-side masters and
// slave, expected requests/responses queued at issue and popped at handshakes.
module tb_ysyx_23060061_mem_arbiter;
    import ysyx_23060061_bus_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid, m0_rsp_ready;
    logic [AW-1:0] m0_req_addr;
    logic [DW-1:0] m0_req_wdata, m0_rsp_rdata;
    logic [MW-1:0] m0_req_wmask;
    logic          m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid, m1_rsp_ready;
    logic [AW-1:0] m1_req_addr;
    logic [DW-1:0] m1_req_wdata, m1_rsp_rdata;
    logic [MW-1:0] m1_req_wmask;
    logic          s_req_valid, s_req_ready, s_req_we, s_rsp_valid, s_rsp_ready, busy;
    logic [AW-1:0] s_req_addr;
    logic [DW-1:0] s_req_wdata, s_rsp_rdata;
    logic [MW-1:0] s_req_wmask;

    ysyx_23060061_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_req_wmask(m0_req_wmask),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_wmask(m1_req_wmask),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
        .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .busy(busy)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
    } req_t;

    typedef struct {
        int   id;
        req_t r;
    } exp_req_t;

    typedef struct {
        int            id;
        logic [DW-1:0] rdata;
    } exp_rsp_t;

    req_t     mq0[$];
    req_t     mq1[$];
    exp_req_t exp_req_q[$];
    exp_rsp_t exp_rsp_q[$];

    int checks = 0;
    int failures = 0;
    int violations = 0;
    int rsp_count = 0;
    int s_stall = 0;
    int m0_hold = 0;
    int m1_hold = 0;
    bit m1_drop = 1'b0;
    bit m0_prev_pend = 1'b0;
    bit m1_prev_pend = 1'b0;
    bit s_pending = 1'b0;
    logic [DW-1:0] s_pend_data = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Contents of the bench's memory slave for reads.
    function automatic logic [DW-1:0] slave_word(input logic [AW-1:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic drive();
        req_t f;
        m0_req_valid = (mq0.size() > 0);
        if (mq0.size() > 0) begin
            f = mq0[0];
            m0_req_we = f.we; m0_req_addr = f.addr; m0_req_wdata = f.wdata; m0_req_wmask = f.wmask;
        end
        m1_req_valid = (mq1.size() > 0) && !m1_drop;
        if (mq1.size() > 0) begin
            f = mq1[0];
            m1_req_we = f.we; m1_req_addr = f.addr; m1_req_wdata = f.wdata; m1_req_wmask = f.wmask;
        end
        m0_rsp_ready = (m0_hold == 0);
        m1_rsp_ready = (m1_hold == 0);
        s_req_ready  = (s_stall == 0) && !s_pending;
        s_rsp_valid  = s_pending;
        s_rsp_rdata  = s_pending ? s_pend_data : '0;
    endtask

    task automatic present();
        drive();
        #1;
    endtask

    task automatic issue(input int id, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [MW-1:0] wmask);
        req_t     r;
        exp_req_t er;
        exp_rsp_t es;
        r.we = we; r.addr = addr; r.wdata = wdata; r.wmask = wmask;
        if (id == 0) mq0.push_back(r);
        else         mq1.push_back(r);
        er.id = id; er.r = r;
        exp_req_q.push_back(er);
        es.id = id;
        es.rdata = we ? '0 : slave_word(addr);
        exp_rsp_q.push_back(es);
    endtask

    task automatic rsp_seen(input int id, input logic [DW-1:0] rdata);
        exp_rsp_t e;
        rsp_count++;
        if (exp_rsp_q.size() == 0) begin
            check("rsp_unexpected", exp_rsp_q.size(), 1);
            return;
        end
        e = exp_rsp_q.pop_front();
        check("rsp_owner", id, e.id);
        check("rsp_rdata", rdata, e.rdata);
    endtask

    // Called at a sample point in the low phase: score this cycle, cross one edge, update models.
    task automatic tick();
        bit            hs_sreq, hs_srsp, hs_m0, hs_m1, saw_sreq, saw_m0_rsp, saw_m1_rsp;
        logic [DW-1:0] nd;
        exp_req_t      e;
        nd         = '0;
        hs_sreq    = s_req_valid && s_req_ready;
        hs_srsp    = s_rsp_valid && s_rsp_ready;
        hs_m0      = m0_req_valid && m0_req_ready;
        hs_m1      = m1_req_valid && m1_req_ready;
        saw_sreq   = s_req_valid;
        saw_m0_rsp = m0_rsp_valid;
        saw_m1_rsp = m1_rsp_valid;

        if (m0_prev_pend && !m0_req_valid) violations++;
        if (m1_prev_pend && !m1_req_valid) violations++;
        m0_prev_pend = m0_req_valid && !m0_req_ready;
        m1_prev_pend = m1_req_valid && !m1_req_ready;

        check("dual_rsp_valid", m0_rsp_valid && m1_rsp_valid, 0);
        if (hs_sreq) begin
            if (exp_req_q.size() == 0) begin
                check("sreq_unexpected", exp_req_q.size(), 1);
            end else begin
                e = exp_req_q.pop_front();
                check("grant_id", m1_req_ready, e.id);
                check("s_req_we", s_req_we, e.r.we);
                check("s_req_addr", s_req_addr, e.r.addr);
                check("s_req_wdata", s_req_wdata, e.r.wdata);
                check("s_req_wmask", s_req_wmask, e.r.wmask);
            end
            nd = s_req_we ? '0 : slave_word(s_req_addr);
        end
        if (m0_rsp_valid && m0_rsp_ready) rsp_seen(0, m0_rsp_rdata);
        if (m1_rsp_valid && m1_rsp_ready) rsp_seen(1, m1_rsp_rdata);

        @(posedge clk);
        @(negedge clk);
        if (hs_m0) void'(mq0.pop_front());
        if (hs_m1) void'(mq1.pop_front());
        if (hs_srsp) s_pending = 1'b0;
        if (hs_sreq) begin
            s_pending   = 1'b1;
            s_pend_data = nd;
        end
        if (s_stall > 0 && saw_sreq)   s_stall--;
        if (m0_hold > 0 && saw_m0_rsp) m0_hold--;
        if (m1_hold > 0 && saw_m1_rsp) m1_hold--;
        present();
    endtask

    task automatic run_until_drained(input int budget);
        int n = 0;
        while ((exp_req_q.size() > 0 || exp_rsp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", exp_req_q.size() + exp_rsp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {m0_req_ready, m0_rsp_valid, m1_req_ready, m1_rsp_valid,
                               s_req_valid, s_rsp_ready, busy}, 0);
        check({tag, "_data"}, |{m0_rsp_rdata, m1_rsp_rdata, s_req_we, s_req_addr,
                               s_req_wdata, s_req_wmask}, 0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        s_pending = 1'b0; s_stall = 0; m0_hold = 0; m1_hold = 0; m1_drop = 1'b0;
        m0_prev_pend = 1'b0; m1_prev_pend = 1'b0;
        present();
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single IFU read straight out of reset: REQ in cycle 1, response in cycle 2.
        issue(0, 1'b0, 32'h8000_0000, '0, '0);
        apply_reset();
        check("c0_s_req_valid", s_req_valid, 0);
        tick();
        check("c1_s_req_valid", s_req_valid, 1);
        check("c1_s_req_addr", s_req_addr, 32'h8000_0000);
        check("c1_m1_outs", {m1_req_ready, m1_rsp_valid, m1_rsp_rdata}, 0);
        tick();
        check("c2_m0_rsp_valid", m0_rsp_valid, 1);
        check("c2_m0_rsp_rdata", m0_rsp_rdata, 32'h0000_0413);
        check("c2_m1_outs", {m1_req_ready, m1_rsp_valid, m1_rsp_rdata}, 0);
        tick();
        check("c3_busy", busy, 0);
        run_until_drained(20);

        // Tie right after reset: IFU first, then the LSU write.
        apply_reset();
        issue(0, 1'b0, 32'h8000_0040, '0, '0);
        issue(1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF);
        present();
        run_until_drained(40);

        // Saturation: strict alternation, one transaction per three cycles.
        issue(0, 1'b0, 32'h8000_0100, '0, '0);
        issue(1, 1'b0, 32'h8000_2000, '0, '0);
        issue(0, 1'b0, 32'h8000_0104, '0, '0);
        issue(1, 1'b1, 32'h8000_2004, 32'h1234_5678, 4'h3);
        present();
        rsp_count = 0;
        repeat (12) tick();
        check("sat_count", rsp_count, 4);
        check("sat_left", exp_req_q.size() + exp_rsp_q.size(), 0);
        run_until_drained(20);

        // Slave stalls the request 5 cycles, then the IFU stalls the response 3 cycles.
        issue(0, 1'b0, 32'h8000_0200, '0, '0);
        issue(1, 1'b0, 32'h8000_3000, '0, '0);
        s_stall = 5;
        m0_hold = 3;
        present();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("req_stall_busy", busy, 1);
            check("req_stall_addr", s_req_addr, 32'h8000_0200);
            check("req_stall_ready", {m0_req_ready, m1_req_ready}, 0);
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("rsp_stall_busy", busy, 1);
            check("rsp_stall_valid", m0_rsp_valid, 1);
            check("rsp_stall_rdata", m0_rsp_rdata, slave_word(32'h8000_0200));
            check("rsp_stall_sready", s_rsp_ready, 0);
            check("rsp_stall_m1", {m1_rsp_valid, m1_req_ready}, 0);
            tick();
        end
        run_until_drained(40);

        // LSU drops req_valid after winning: grant still stands, bench flags it.
        violations = 0;
        issue(1, 1'b0, 32'h8000_4000, '0, '0);
        present();
        tick();
        m1_drop = 1'b1;
        present();
        run_until_drained(20);
        check("violation_flagged", violations, 1);
        mq1.delete();
        m1_drop = 1'b0;
        present();

        // Asynchronous reset while in RSP drops the transaction; pending LSU wins next edge.
        issue(0, 1'b0, 32'h8000_0300, '0, '0);
        issue(1, 1'b0, 32'h8000_5000, '0, '0);
        m0_hold = 100;
        present();
        tick();
        tick();
        tick();
        check("pre_rst_in_rsp", m0_rsp_valid, 1);
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        void'(exp_rsp_q.pop_front());
        s_pending = 1'b0; m0_hold = 0;
        m0_prev_pend = 1'b0; m1_prev_pend = 1'b0;
        present();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_busy", busy, 0);
        tick();
        check("post_rst_grant", {busy, s_req_valid, m1_req_ready}, 3'b111);
        check("post_rst_addr", s_req_addr, 32'h8000_5000);
        run_until_drained(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
